contador_timer_ctrl: RTL and testbench
======================================

// Module: contador_timer_ctrl
// PURPOSE
//   Run-control sequencer for the binary counter datapath. Owns a WIDTH-bit counter
//   and controls it with start/pause/abort. Supports one-shot and periodic modes.
//   Counts 0..limit, flags terminal count, and tallies periodic completions.
//   Sits between the system control logic and the counter; turns the free-running
//   counter into a programmable interval timer.
// PARAMETERS
//   WIDTH     4  counter / limit width (bits)
//   PERIODS_W 4  width of periodic-completion tally
// PORTS
//   clk       in   1          system clock, all logic on rising edge
//   rst       in   1          synchronous reset, active-high
//   start     in   1          launch request (sampled in IDLE/DONE only)
//   pause     in   1          level: hold count while high (RUN/PAUSED)
//   abort     in   1          cancel run, return to IDLE
//   limit     in   WIDTH      terminal count, latched on accepted start
//   periodic  in   1          1=auto-restart at terminal, latched on accepted start
//   q         out  WIDTH      current count
//   busy      out  1          1 in RUN or PAUSED
//   done      out  1          1-cycle pulse on terminal count
//   wraps     out  PERIODS_W  periodic completions since last start, mod 2^PERIODS_W
//   state     out  2          IDLE=0 RUN=1 PAUSED=2 DONE=3
// BEHAVIOUR
//   Single clock domain. Reset is synchronous and active-high.
//   All outputs are registered.
//   Reset: state=IDLE, q=0, busy=0, done=0, wraps=0, latched limit/periodic=0.
//   Event priority each edge: rst > abort > pause > terminal > increment.
//   done defaults to 0 every cycle unless set below.
//   IDLE:
//     - start=1: latch limit and periodic; q<=0; wraps<=0; go to RUN.
//     - Otherwise hold, q=0.
//   RUN:
//     - abort: go to IDLE, q<=0.
//     - pause: go to PAUSED, q holds.
//     - q==lim_r with periodic: done<=1, q<=0, wraps<=wraps+1 (wraps modulo), stay in RUN.
//     - q==lim_r one-shot: done<=1, go to DONE, q holds lim_r.
//     - Otherwise: q<=q+1.
//     - start is ignored.
//   PAUSED:
//     - abort: go to IDLE, q<=0.
//     - pause=0: go to RUN, counting resumes on the following edge.
//     - Otherwise hold. start is ignored.
//   DONE:
//     - start: relaunch exactly as from IDLE (new limit latched, wraps cleared).
//     - abort: go to IDLE, q<=0.
//     - Otherwise hold q=lim_r.
//   Timing:
//     - With start sampled at edge 0, q=k after edge k (k<=lim).
//     - done is high in the cycle after edge lim+1.
//     - Periodic period = lim+1 cycles.
//   Pause coinciding with terminal: pause wins; done is deferred until after resume.
//   limit=0: the run terminates at the first RUN edge. In periodic mode done stays
//   high every cycle and wraps increments each cycle.
//   limit and periodic changes during RUN/PAUSED have no effect until the next start.
//   q never exceeds lim_r. No overflow path, since lim_r <= 2^WIDTH-1.
//   Reset mid-operation: next edge yields all reset values, regardless of state.
// TESTING
//   1 rst=1 for 3 cycles, then 0 -> q=0, state=0, busy=0, done=0, wraps=0.
//   2 One-shot limit=5, 1-cycle start -> q 0,1,..,5; a single done pulse; state=3;
//     q held at 5; busy=0. A second start with limit=2 -> counts 0..2 again.
//   3 Periodic limit=3, run 40 cycles -> q 0,1,2,3,0,..; done every 4th cycle;
//     wraps=10. Periodic limit=15 -> q 15->0 wrap; 16 completions -> wraps 15->0.
//   4 pause high for 4 cycles at q=2 -> q stays 2, state=2, busy=1; then q=3.
//     pause at q==limit -> no done until one cycle after release.
//   5 abort in RUN (q=4) and in PAUSED -> state=0, q=0 next edge.
//     rst at q=7 -> reset values. start during RUN -> no effect on q or limit.
//   6 limit=0 periodic -> done continuously high, q=0, wraps +1 per cycle.
//     limit=0 one-shot -> done pulse, then state=3.

Source files
------------

// File: rtl/contador_timer_ctrl.sv
// Run-control sequencer for a WIDTH-bit interval counter: start/pause/abort,
// one-shot or periodic operation, terminal-count pulse and periodic tally.
module contador_timer_ctrl #(
  parameter int WIDTH     = 4,
  parameter int PERIODS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     limit,
  input  logic                 periodic,
  output logic [WIDTH-1:0]     q,
  output logic                 busy,
  output logic                 done,
  output logic [PERIODS_W-1:0] wraps,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t               st, st_n;
  logic [WIDTH-1:0]     lim_r, lim_n, q_n;
  logic                 per_r, per_n, done_n;
  logic [PERIODS_W-1:0] wraps_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= IDLE;
      q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      wraps <= '0;
      lim_r <= '0;
      per_r <= 1'b0;
    end else begin
      st    <= st_n;
      q     <= q_n;
      busy  <= (st_n == RUN) || (st_n == PAUSED);
      done  <= done_n;
      wraps <= wraps_n;
      lim_r <= lim_n;
      per_r <= per_n;
    end
  end

  // Priority within each state: abort > pause > terminal > increment.
  always_comb begin
    st_n    = st;
    q_n     = q;
    wraps_n = wraps;
    done_n  = 1'b0;
    lim_n   = lim_r;
    per_n   = per_r;
    case (st)
      IDLE, DONE: begin
        if (abort) begin
          st_n = IDLE;
          q_n  = '0;
        end else if (start) begin
          lim_n   = limit;
          per_n   = periodic;
          q_n     = '0;
          wraps_n = '0;
          st_n    = RUN;
        end else if (st == IDLE) begin
          q_n = '0;
        end
      end
      RUN: begin
        if (abort) begin
          st_n = IDLE;
          q_n  = '0;
        end else if (pause) begin
          st_n = PAUSED;
        end else if (q == lim_r) begin
          done_n = 1'b1;
          if (per_r) begin
            q_n     = '0;
            wraps_n = wraps + 1'b1;
          end else begin
            st_n = DONE;
          end
        end else begin
          q_n = q + 1'b1;
        end
      end
      PAUSED: begin
        if (abort) begin
          st_n = IDLE;
          q_n  = '0;
        end else if (!pause) begin
          st_n = RUN;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  assign state = st;

endmodule

// File: tb/tb_contador_timer_ctrl.sv
// Bench for contador_timer_ctrl: directed scenarios plus a randomized run
// checked against a tick-counting reference model.
module tb_contador_timer_ctrl;
  localparam int W  = 4;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst, start, pause, abort, periodic;
  logic [W-1:0]  limit;
  logic [W-1:0]  q;
  logic          busy, done;
  logic [PW-1:0] wraps;
  logic [1:0]    state;

  int passed = 0;
  int total  = 0;

  contador_timer_ctrl #(.WIDTH(W), .PERIODS_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .limit(limit), .periodic(periodic), .q(q), .busy(busy), .done(done),
    .wraps(wraps), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: a run is described by the number of counting edges
  // since launch; q, done and wraps follow arithmetically from that count.
  int m_st;     // 0 idle, 1 counting, 2 held, 3 finished
  int m_ticks;
  int m_lim;
  int m_per;
  int m_done;

  function automatic void model_step();
    m_done = 0;
    if (rst) begin
      m_st = 0; m_ticks = 0; m_lim = 0; m_per = 0;
    end else if (m_st == 0 || m_st == 3) begin
      if (abort) m_st = 0;
      else if (start) begin
        m_lim = int'(limit); m_per = int'(periodic); m_ticks = 0; m_st = 1;
      end
    end else if (m_st == 1) begin
      if (abort) m_st = 0;
      else if (pause) m_st = 2;
      else begin
        m_ticks++;
        if (m_per != 0) m_done = (m_ticks % (m_lim + 1) == 0) ? 1 : 0;
        else if (m_ticks == m_lim + 1) begin
          m_done = 1; m_st = 3;
        end
      end
    end else begin
      if (abort) m_st = 0;
      else if (!pause) m_st = 1;
    end
  endfunction

  function automatic int exp_q();
    if (m_st == 0) return 0;
    if (m_per != 0) return m_ticks % (m_lim + 1);
    return (m_ticks > m_lim) ? m_lim : m_ticks;
  endfunction

  function automatic int exp_wraps();
    return (m_per != 0) ? (m_ticks / (m_lim + 1)) % (1 << PW) : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
  endtask

  task automatic launch(input int lim, input bit per);
    limit = W'(lim); periodic = per; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
    limit = '0; periodic = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    total++;
    if ({q, state, busy, done, wraps} !== '0)
      $display("FAIL reset: q=%0d state=%0d busy=%0b done=%0b wraps=%0d, expected all 0",
               q, state, busy, done, wraps);
    else passed++;
  endtask

  task automatic test_oneshot();
    launch(5, 1'b0);
    total++;
    if (q !== 0 || state !== 2'd1 || busy !== 1'b1)
      $display("FAIL oneshot_launch: q=%0d state=%0d busy=%0b, expected 0/1/1", q, state, busy);
    else passed++;
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++;
      if (q !== W'(k) || done !== 1'b0)
        $display("FAIL oneshot_count: q=%0d done=%0b, expected %0d/0", q, done, k);
      else passed++;
    end
    tick();
    total++;
    if (done !== 1'b1 || state !== 2'd3 || busy !== 1'b0 || q !== 4'd5)
      $display("FAIL oneshot_term: done=%0b state=%0d busy=%0b q=%0d, expected 1/3/0/5",
               done, state, busy, q);
    else passed++;
    tick();
    total++;
    if (done !== 1'b0 || q !== 4'd5 || state !== 2'd3)
      $display("FAIL oneshot_hold: done=%0b q=%0d state=%0d, expected 0/5/3", done, q, state);
    else passed++;
    launch(2, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++;
      if (q !== W'((k > 2) ? 2 : k) || done !== (k == 3))
        $display("FAIL oneshot_relaunch: q=%0d done=%0b at edge %0d", q, done, k);
      else passed++;
    end
  endtask

  task automatic test_periodic();
    launch(3, 1'b1);
    for (int i = 1; i <= 40; i++) begin
      tick();
      total++;
      if (q !== W'(i % 4) || done !== (i % 4 == 0))
        $display("FAIL periodic3: edge %0d q=%0d done=%0b, expected %0d/%0b",
                 i, q, done, i % 4, i % 4 == 0);
      else passed++;
    end
    total++;
    if (wraps !== 4'd10) $display("FAIL periodic3_wraps: got %0d, expected 10", wraps);
    else passed++;
    abort = 1'b1; tick(); abort = 1'b0;
    launch(15, 1'b1);
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i == 15 || i == 16) begin
        total++;
        if (q !== W'(i % 16)) $display("FAIL periodic15_q: edge %0d q=%0d expected %0d", i, q, i % 16);
        else passed++;
      end
      if (i == 240 || i == 256) begin
        total++;
        if (wraps !== PW'(i / 16)) $display("FAIL periodic15_wraps: edge %0d wraps=%0d expected %0d",
                                            i, wraps, (i / 16) % 16);
        else passed++;
      end
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_pause();
    launch(9, 1'b0);
    tick(); tick();
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (q !== 4'd2 || state !== 2'd2 || busy !== 1'b1)
        $display("FAIL pause_hold: q=%0d state=%0d busy=%0b, expected 2/2/1", q, state, busy);
      else passed++;
    end
    pause = 1'b0;
    tick(); tick();
    total++;
    if (q !== 4'd3 || state !== 2'd1)
      $display("FAIL pause_resume: q=%0d state=%0d, expected 3/1", q, state);
    else passed++;
    abort = 1'b1; tick(); abort = 1'b0;
    launch(4, 1'b0);
    repeat (4) tick();
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (done !== 1'b0 || q !== 4'd4)
        $display("FAIL pause_term_hold: done=%0b q=%0d, expected 0/4", done, q);
      else passed++;
    end
    pause = 1'b0;
    tick();
    total++;
    if (done !== 1'b0 || state !== 2'd1)
      $display("FAIL pause_term_release: done=%0b state=%0d, expected 0/1", done, state);
    else passed++;
    tick();
    total++;
    if (done !== 1'b1 || state !== 2'd3)
      $display("FAIL pause_term_done: done=%0b state=%0d, expected 1/3", done, state);
    else passed++;
  endtask

  task automatic test_abort();
    launch(9, 1'b0);
    repeat (4) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    total++;
    if (q !== 0 || state !== 2'd0 || busy !== 1'b0)
      $display("FAIL abort_run: q=%0d state=%0d busy=%0b, expected 0/0/0", q, state, busy);
    else passed++;
    launch(9, 1'b0);
    tick(); tick();
    pause = 1'b1; tick(); tick();
    abort = 1'b1; tick(); abort = 1'b0; pause = 1'b0;
    total++;
    if (q !== 0 || state !== 2'd0)
      $display("FAIL abort_paused: q=%0d state=%0d, expected 0/0", q, state);
    else passed++;
    launch(9, 1'b1);
    repeat (7) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    total++;
    if ({q, state, busy, done, wraps} !== '0)
      $display("FAIL reset_mid: q=%0d state=%0d busy=%0b done=%0b wraps=%0d, expected all 0",
               q, state, busy, done, wraps);
    else passed++;
    launch(9, 1'b0);
    repeat (3) tick();
    limit = 4'd2; start = 1'b1; tick(); start = 1'b0;
    total++;
    if (q !== 4'd4 || state !== 2'd1)
      $display("FAIL start_in_run: q=%0d state=%0d, expected 4/1", q, state);
    else passed++;
    repeat (5) tick();
    total++;
    if (q !== 4'd9 || done !== 1'b0)
      $display("FAIL start_in_run_limit: q=%0d done=%0b, expected 9/0", q, done);
    else passed++;
    tick();
    total++;
    if (done !== 1'b1 || state !== 2'd3)
      $display("FAIL start_in_run_done: done=%0b state=%0d, expected 1/3", done, state);
    else passed++;
  endtask

  task automatic test_limit0();
    launch(0, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      total++;
      if (done !== 1'b1 || q !== 0 || wraps !== PW'(i))
        $display("FAIL limit0_periodic: done=%0b q=%0d wraps=%0d, expected 1/0/%0d", done, q, wraps, i);
      else passed++;
    end
    abort = 1'b1; tick(); abort = 1'b0;
    launch(0, 1'b0);
    tick();
    total++;
    if (done !== 1'b1 || state !== 2'd3)
      $display("FAIL limit0_oneshot: done=%0b state=%0d, expected 1/3", done, state);
    else passed++;
    tick();
    total++;
    if (done !== 1'b0 || state !== 2'd3)
      $display("FAIL limit0_oneshot_after: done=%0b state=%0d, expected 0/3", done, state);
    else passed++;
  endtask

  task automatic test_random();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 199) == 0);
      abort    = ($urandom_range(0, 39) == 0);
      start    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      limit    = W'($urandom_range(0, 15));
      periodic = $urandom_range(0, 1) == 1;
      tick();
      total++;
      if (q !== W'(exp_q()) || state !== 2'(m_st) || busy !== (m_st == 1 || m_st == 2) ||
          done !== 1'(m_done) || wraps !== PW'(exp_wraps()))
        $display("FAIL random c=%0d: q=%0d state=%0d busy=%0b done=%0b wraps=%0d, expected %0d/%0d/%0b/%0d/%0d",
                 c, q, state, busy, done, wraps, exp_q(), m_st, (m_st == 1 || m_st == 2), m_done, exp_wraps());
      else passed++;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_abort();
    test_limit0();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
